// File: rtl/point_stream_tx_if.sv
// point_stream_tx_if: point-in / coordinate-word-out handshake bundle
interface point_stream_tx_if #(
  parameter int WORD_BITS = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [3*WORD_BITS-1:0] in_point;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_BITS-1:0]   out_word;
  logic [1:0]             out_lane;
  logic                   out_last;
  modport master (
    output in_valid, in_point, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_lane, out_last
  );
  modport slave (
    input  in_valid, in_point, in_last, out_ready,
    output in_ready, out_valid, out_word, out_lane, out_last
  );
endinterface

// File: rtl/point_stream_tx.sv
// point_stream_tx: serializes a 3-coordinate point into x, y, z words with lane tags
module point_stream_tx #(
  parameter int WORD_BITS  = 32,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  point_stream_tx_if.slave      bus,
  output logic [COUNT_BITS-1:0] points_sent,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SEND_X, SEND_Y, SEND_Z} state_t;
  state_t                 state;
  logic [3*WORD_BITS-1:0] hold;
  logic                   hold_last;
  logic                   in_hs;
  logic                   out_hs;
  assign bus.in_ready = !rst && (state == IDLE || (state == SEND_Z && bus.out_ready));
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign out_hs       = bus.out_valid && bus.out_ready;
  // Outputs decode only registered state and the hold register, so no input reaches them combinationally
  always_comb begin
    bus.out_valid = state != IDLE;
    busy          = state != IDLE;
    bus.out_word  = state == SEND_X ? hold[3*WORD_BITS-1:2*WORD_BITS] :
                    state == SEND_Y ? hold[2*WORD_BITS-1:WORD_BITS] :
                    state == SEND_Z ? hold[WORD_BITS-1:0] : '0;
    bus.out_lane  = state == SEND_Y ? 2'd1 : state == SEND_Z ? 2'd2 : 2'd0;
    bus.out_last  = state == SEND_Z && hold_last;
  end
  // FSM: load on input handshake, step x->y->z on output handshakes, reload straight from z when a new point arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold        <= '0;
      hold_last   <= 1'b0;
      points_sent <= '0;
    end else begin
      if (in_hs) begin
        hold      <= bus.in_point;
        hold_last <= bus.in_last;
      end
      if (out_hs && state == SEND_Z) points_sent <= points_sent + 1'b1;
      state <= in_hs              ? SEND_X :
               !out_hs            ? state  :
               state == SEND_X    ? SEND_Y :
               state == SEND_Y    ? SEND_Z : IDLE;
    end
  end
endmodule

// File: tb/tb_point_stream_tx.sv
// tb_point_stream_tx: table-driven directed tests plus scoreboard-checked random stress
module tb_point_stream_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ps;
  logic [1:0]  ps2;
  logic        busy;
  logic        busy2;
  int          checks = 0;
  int          errors = 0;
  int          model_cnt = 0;
  typedef struct packed {logic [31:0] w; logic [1:0] l; logic t;} exp_t;
  typedef struct {logic [95:0] point; logic last; logic [31:0] ex, ey, ez; logic el;} vec_t;
  exp_t sbq[$];
  exp_t e;
  vec_t tv[4];
  int   wrap_exp[5];
  always #5 clk = ~clk;
  point_stream_tx_if #(.WORD_BITS(32)) bus ();
  point_stream_tx_if #(.WORD_BITS(32)) bus2 ();
  point_stream_tx #(.WORD_BITS(32), .COUNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .points_sent(ps), .busy(busy)
  );
  point_stream_tx #(.WORD_BITS(32), .COUNT_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .points_sent(ps2), .busy(busy2)
  );
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_point  = bus.in_point;
  assign bus2.in_last   = bus.in_last;
  assign bus2.out_ready = bus.out_ready;
  task automatic chk(string n, logic [63:0] a, logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Scoreboard: accepted points push three expected words, output handshakes pop and compare
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      model_cnt = 0;
    end else begin
      chk("points_sent", ps, 64'(16'(model_cnt)));
      chk("points_sent_wrap", ps2, 64'(model_cnt % 4));
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got word %0h lane %0d, expected no word", bus.out_word, bus.out_lane);
        end else begin
          e = sbq.pop_front();
          chk("sb_word", {bus.out_word, bus.out_lane, bus.out_last}, 64'(e));
          if (e.l == 2'd2) model_cnt++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sbq.push_back({bus.in_point[95:64], 2'd0, 1'b0});
        sbq.push_back({bus.in_point[63:32], 2'd1, 1'b0});
        sbq.push_back({bus.in_point[31:0],  2'd2, bus.in_last});
      end
    end
  end
  initial begin
    int k, acc, cyc;
    logic hs;
    tv[0] = '{96'h00100000_FFF00000_7FFFFFFF, 1'b0, 32'h00100000, 32'hFFF00000, 32'h7FFFFFFF, 1'b0};
    tv[1] = '{96'h80000000_00000001_DEADBEEF, 1'b1, 32'h80000000, 32'h00000001, 32'hDEADBEEF, 1'b1};
    tv[2] = '{96'h0,                          1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    tv[3] = '{96'hFFFFFFFF_12345678_A5A5A5A5, 1'b1, 32'hFFFFFFFF, 32'h12345678, 32'hA5A5A5A5, 1'b1};
    wrap_exp = '{1, 2, 3, 0, 1};
    bus.in_valid  = 1'b0;
    bus.in_point  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    tick;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_word", bus.out_word, 0);
    chk("rst_out_lane", bus.out_lane, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_points_sent", ps, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_point = tv[i].point;
      bus.in_last  = tv[i].last;
      tick;
      bus.in_valid = 1'b0;
      bus.in_point = {$urandom, $urandom, $urandom};
      bus.in_last  = 1'b1;
      chk("sp_x_valid", bus.out_valid, 1);
      chk("sp_x", {bus.out_word, bus.out_lane, bus.out_last}, {tv[i].ex, 2'd0, 1'b0});
      tick;
      chk("sp_y", {bus.out_word, bus.out_lane, bus.out_last}, {tv[i].ey, 2'd1, 1'b0});
      tick;
      chk("sp_z", {bus.out_word, bus.out_lane, bus.out_last}, {tv[i].ez, 2'd2, tv[i].el});
      chk("sp_z_in_ready", bus.in_ready, 1);
      tick;
      chk("sp_idle_valid", bus.out_valid, 0);
      chk("sp_idle_busy", busy, 0);
      chk("sp_points_sent", ps, i + 1);
    end
    k = 0;
    bus.in_valid = 1'b1;
    bus.in_point = tv[0].point;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 13; c++) begin
      hs = bus.in_valid && bus.in_ready;
      tick;
      if (hs) begin
        k++;
        if (k < 4) begin
          bus.in_point = tv[k].point;
          bus.in_last  = k == 3;
        end else bus.in_valid = 1'b0;
      end
      chk("b2b_valid", bus.out_valid, c < 12);
      chk("b2b_last", bus.out_last, c == 11);
      chk("b2b_in_ready", bus.in_ready, c % 3 == 2 || c == 12);
    end
    chk("b2b_points_sent", ps, 8);
    bus.in_valid = 1'b1;
    bus.in_point = tv[1].point;
    bus.in_last  = 1'b0;
    tick;
    bus.in_valid = 1'b0;
    tick;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold", {bus.out_valid, bus.out_word, bus.out_lane}, {1'b1, tv[1].ey, 2'd1});
      chk("bp_in_ready", bus.in_ready, 0);
      tick;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", bus.in_ready, 0);
    tick;
    chk("bp_z", {bus.out_word, bus.out_lane, bus.out_last}, {tv[1].ez, 2'd2, 1'b0});
    tick;
    chk("bp_points_sent", ps, 9);
    bus.in_valid = 1'b1;
    bus.in_point = tv[3].point;
    bus.in_last  = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    chk("rmp_in_y", bus.out_lane, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("rmp_out_valid", bus.out_valid, 0);
    chk("rmp_points_sent", ps, 0);
    chk("rmp_in_ready", bus.in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("rmp_no_z", bus.out_valid, 0);
    end
    for (int j = 0; j < 5; j++) begin
      bus.in_valid = 1'b1;
      bus.in_point = {$urandom, $urandom, $urandom};
      bus.in_last  = 1'b0;
      tick;
      bus.in_valid = 1'b0;
      tick;
      tick;
      tick;
      chk("wrap_seq", ps2, wrap_exp[j]);
    end
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 40000) begin
      bus.in_valid  = 1'($urandom % 2);
      bus.in_point  = {$urandom, $urandom, $urandom};
      bus.in_last   = 1'($urandom % 2);
      bus.out_ready = 1'($urandom % 2);
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      tick;
      cyc++;
    end
    chk("stress_points", acc, 1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && sbq.size() != 0; c++) tick;
    tick;
    chk("stress_drain", sbq.size(), 0);
    chk("stress_idle", bus.out_valid, 0);
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/point_stream_tx.md
# point_stream_tx

Serializes `vector::point_t` (three `single_t` Q12.20 coordinates, 96 bits) into a stream of 32-bit coordinate words, ordered x, y, z. It is the transmit end of the point-word link between the RANSAC core and narrow buses such as the host DMA and debug FIFO. It includes lane tagging, end-of-cloud marking and a sent-point counter. Throughput is one point per three cycles with no bubbles between points.

## Interface
Parameters:
- `WORD_BITS`, default `vector::bits_in_single` (32): output word width; must equal `$bits(vector::single_t)`.
- `COUNT_BITS`, default 16: width of `points_sent`.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_point`/`in_last` valid.
- `in_ready`  out  1  block accepts a point this cycle.
- `in_point`  in  96  `vector::point_t`; x = bits [95:64], y = [63:32], z = [31:0].
- `in_last`  in  1  this point is the final point of a cloud.
- `out_valid`  out  1  `out_word` valid.
- `out_ready`  in  1  sink accepts the word.
- `out_word`  out  `WORD_BITS`  `vector::single_t` coordinate.
- `out_lane`  out  2  0 = x, 1 = y, 2 = z; 3 never driven.
- `out_last`  out  1  set only on the z word of a point that was accepted with `in_last`=1.
- `points_sent`  out  `COUNT_BITS`  count of completed z handshakes, modulo 2^`COUNT_BITS`.
- `busy`  out  1  a point is held (state != IDLE).

## Operation
- FSM states: IDLE, SEND_X, SEND_Y, SEND_Z.
- The input handshake is `in_valid && in_ready`. On a handshake, latch `in_point` and `in_last` into a hold register and go to SEND_X.
- `in_ready` = !`rst` && (state==IDLE || (state==SEND_Z && `out_ready`)). In SEND_Z, a point accepted in the same cycle as the z handshake goes directly to SEND_X with no idle cycle.
- Output words are registered from the hold register:
  - SEND_X drives x with lane 0.
  - SEND_Y drives y with lane 1.
  - SEND_Z drives z with lane 2 and `out_last` = latched `in_last`.
- `out_valid` = 1 in SEND_X, SEND_Y and SEND_Z, and 0 in IDLE.
- An output handshake is `out_valid && out_ready`. On a handshake the FSM advances X→Y→Z. From Z it goes to SEND_X if a new point is accepted in the same cycle, otherwise to IDLE.
- While `out_valid && !out_ready`, `out_word`, `out_lane` and `out_last` stay stable and the state holds.
- `points_sent` increments by 1 on each z handshake and wraps from all-ones to 0 with no flag.
- Words pass through bit-exact. There is no rounding, saturation or sign change.
- `in_point` is ignored whenever `in_ready`=0.

## Timing
- Reset values: state IDLE; `out_valid` 0; `out_word` 0; `out_lane` 0; `out_last` 0; `points_sent` 0; `busy` 0. `in_ready` is 0 during the cycle `rst` is high and 1 in the first cycle after.
- Latency: a point accepted at edge n presents x at cycle n+1.
- With `out_ready` held at 1, y appears at n+2, z at n+3, and `points_sent` updates at the edge that completes z.
- Sustained rate is 3 cycles per point.
- When `rst` is asserted mid-point (any SEND_* state), the held point is discarded. No remaining words are emitted and the counter clears. The following cycle matches the post-reset state.
- Simultaneous z handshake and input handshake: the counter increments and the new point's x is visible on the next cycle.
- `in_ready` combinationally depends on `out_ready` only in SEND_Z. No other combinational input-to-output path exists.

## Test plan
- Single point: after reset, present x=0x00100000, y=0xFFF00000, z=0x7FFFFFFF, `in_last`=0, with `out_ready`=1.
  - Required: words 0x00100000/0, 0xFFF00000/1, 0x7FFFFFFF/2 on cycles n+1..n+3.
  - `out_last` stays 0; `points_sent`=1; `busy` falls after z.
- Back-to-back: 4 points with `in_valid` held high and `out_ready`=1, last point `in_last`=1.
  - Required: 12 consecutive valid words with no gap.
  - `in_ready` pulses only with each z handshake.
  - `out_last`=1 only on word 12; `points_sent`=4.
- Backpressure: drop `out_ready` for 5 cycles while y is presented.
  - Required: y word and lane 1 held stable for all 5 cycles.
  - `in_ready`=0 throughout; z follows exactly one cycle after `out_ready` returns.
- Reset mid-point: assert `rst` for one cycle in SEND_Y.
  - Required: next cycle `out_valid`=0, `points_sent`=0, `in_ready`=1.
  - No z word is ever emitted for that point.
- Counter wrap (`COUNT_BITS`=2): send 5 points.
  - Required: `points_sent` sequence 1, 2, 3, 0, 1.
- Random stress: random `in_valid`/`out_ready` at 50% over 1000 points.
  - Required: scoreboard shows every word bit-exact in x, y, z order with correct lanes, and `points_sent` matches the model count modulo 2^`COUNT_BITS`.
